// File: rtl/ad80305_rx_if_ddr_lvcmos_deframer_if.sv
// Bus bundle between the IDDR capture stage and the AD80305 RX deframer.
// The master side drives the captured words/frame bits; the deframer (slave) drives samples and status.
interface ad80305_rx_if_ddr_lvcmos_deframer_if #(
    parameter int DW = 12
);
    logic [DW-1:0] i_rx_data_h;
    logic [DW-1:0] i_rx_data_l;
    logic          i_rx_frame_h;
    logic          i_rx_frame_l;
    logic          i_err_clr;
    logic [DW-1:0] o_rx_idata;
    logic [DW-1:0] o_rx_qdata;
    logic          o_rx_iqdata_fp;
    logic          o_lock;
    logic          o_align_shift;
    logic [15:0]   o_frame_err_cnt;

    modport master (
        output i_rx_data_h, i_rx_data_l, i_rx_frame_h, i_rx_frame_l, i_err_clr,
        input  o_rx_idata, o_rx_qdata, o_rx_iqdata_fp, o_lock, o_align_shift, o_frame_err_cnt
    );

    modport slave (
        input  i_rx_data_h, i_rx_data_l, i_rx_frame_h, i_rx_frame_l, i_err_clr,
        output o_rx_idata, o_rx_qdata, o_rx_iqdata_fp, o_lock, o_align_shift, o_frame_err_cnt
    );
endinterface

// File: rtl/ad80305_rx_if_ddr_lvcmos_deframer.sv
// AD80305 DDR LVCMOS RX deframer: locks to RX_FRAME (NORMAL/SHIFTED) and emits one I/Q pair per clock.
// Latency 2 clocks input to sample; no backpressure, the consumer must take every strobed sample.
module ad80305_rx_if_ddr_lvcmos_deframer #(
    parameter int DW         = 12,
    parameter int LOCK_CNT   = 8,
    parameter int UNLOCK_CNT = 4,
    parameter int SWAP_IQ    = 0
) (
    input  logic                                   i_fpga_clk,
    input  logic                                   i_fpga_rst,
    ad80305_rx_if_ddr_lvcmos_deframer_if.slave     rx
);
    typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_t;

    localparam logic [7:0] LOCK_THR   = 8'(LOCK_CNT);
    localparam logic [7:0] UNLOCK_THR = 8'(UNLOCK_CNT);
    localparam bit         SWAP       = (SWAP_IQ != 0);

    logic [DW-1:0] r_h, r_l, r_l_d;
    logic          r_fh, r_fl;

    state_t        state, state_n;
    logic [7:0]    good_cnt, good_n;
    logic [7:0]    bad_cnt, bad_n;
    logic          r_mode, mode_n;
    logic          load, err_inc;

    logic [DW-1:0] idata_q, qdata_q;
    logic          fp_q;
    logic [15:0]   err_q;

    always_ff @(posedge i_fpga_clk) begin
        if (i_fpga_rst) begin
            r_h   <= '0;
            r_l   <= '0;
            r_l_d <= '0;
            r_fh  <= 1'b0;
            r_fl  <= 1'b0;
        end else begin
            r_h   <= rx.i_rx_data_h;
            r_l   <= rx.i_rx_data_l;
            r_l_d <= r_l;
            r_fh  <= rx.i_rx_frame_h;
            r_fl  <= rx.i_rx_frame_l;
        end
    end

    // Only 10 and 01 are legal; the low bit alone then names the mode (1 = SHIFTED).
    logic p_valid, p_mode, p_match;
    assign p_valid = r_fh ^ r_fl;
    assign p_mode  = r_fl;
    assign p_match = p_valid && (p_mode == r_mode);

    always_ff @(posedge i_fpga_clk) begin
        if (i_fpga_rst) begin
            state    <= SEARCH;
            good_cnt <= '0;
            bad_cnt  <= '0;
            r_mode   <= 1'b0;
        end else begin
            state    <= state_n;
            good_cnt <= good_n;
            bad_cnt  <= bad_n;
            r_mode   <= mode_n;
        end
    end

    always_comb begin
        state_n = state;
        good_n  = good_cnt;
        bad_n   = bad_cnt;
        mode_n  = r_mode;
        load    = 1'b0;
        err_inc = 1'b0;
        case (state)
            SEARCH: begin
                if (p_valid) begin
                    mode_n = p_mode;
                    good_n = 8'd1;
                    if (LOCK_THR == 8'd1) begin
                        state_n = LOCKED;
                        bad_n   = '0;
                    end else begin
                        state_n = CHECK;
                    end
                end
            end
            CHECK: begin
                if (p_match) begin
                    good_n = good_cnt + 8'd1;
                    if ((good_cnt + 8'd1) == LOCK_THR) begin
                        state_n = LOCKED;
                        bad_n   = '0;
                    end
                end else if (p_valid) begin
                    mode_n = p_mode;
                    good_n = 8'd1;
                end else begin
                    state_n = SEARCH;
                    good_n  = '0;
                end
            end
            LOCKED: begin
                if (p_match) begin
                    bad_n = '0;
                    load  = 1'b1;
                end else begin
                    // The opposite valid mode is an error too: realignment only through SEARCH.
                    err_inc = 1'b1;
                    bad_n   = bad_cnt + 8'd1;
                    if ((bad_cnt + 8'd1) == UNLOCK_THR) begin
                        state_n = SEARCH;
                        good_n  = '0;
                        bad_n   = '0;
                    end
                end
            end
            default: begin
                state_n = SEARCH;
                good_n  = '0;
                bad_n   = '0;
            end
        endcase
    end

    // SHIFTED pairs the previous falling-edge word with the current rising-edge word.
    logic [DW-1:0] s_i, s_q;
    assign s_i = r_mode ? r_l_d : r_h;
    assign s_q = r_mode ? r_h   : r_l;

    always_ff @(posedge i_fpga_clk) begin
        if (i_fpga_rst) begin
            idata_q <= '0;
            qdata_q <= '0;
            fp_q    <= 1'b0;
            err_q   <= '0;
        end else begin
            fp_q <= load;
            if (load) begin
                idata_q <= SWAP ? s_q : s_i;
                qdata_q <= SWAP ? s_i : s_q;
            end
            if (rx.i_err_clr) begin
                err_q <= '0;
            end else if (err_inc && (err_q != 16'hFFFF)) begin
                err_q <= err_q + 16'd1;
            end
        end
    end

    assign rx.o_rx_idata      = idata_q;
    assign rx.o_rx_qdata      = qdata_q;
    assign rx.o_rx_iqdata_fp  = fp_q;
    assign rx.o_lock          = (state == LOCKED);
    assign rx.o_align_shift   = r_mode;
    assign rx.o_frame_err_cnt = err_q;
endmodule

// File: doc/ad80305_rx_if_ddr_lvcmos_deframer.md
# ad80305_rx_if_ddr_lvcmos_deframer

Receive-side deframer for the AD80305 DDR LVCMOS data port, and the counterpart of the transmit interface. It sits behind the IDDR capture primitive and receives one rising-edge word and one falling-edge word per clock. It searches for the RX_FRAME pattern and locks to it. Once locked it emits one aligned I/Q sample per clock with a data strobe, and it reports lock state and frame-error statistics to the control logic.

## Interface
Parameters:
- DW, 12, sample width of I and Q.
- LOCK_CNT, 8, consecutive matching frame patterns needed to lock (range 1..255).
- UNLOCK_CNT, 4, consecutive non-matching patterns that drop lock (range 1..255).
- SWAP_IQ, 0, when 1 the I and Q outputs are exchanged.

Ports:
- i_fpga_clk  in  1  RX data clock; the only clock in the block.
- i_fpga_rst  in  1  synchronous, active-high reset.
- i_rx_data_h  in  DW  word captured on the rising edge of DATA_CLK.
- i_rx_data_l  in  DW  word captured on the falling edge of DATA_CLK.
- i_rx_frame_h  in  1  RX_FRAME captured on the rising edge.
- i_rx_frame_l  in  1  RX_FRAME captured on the falling edge.
- i_err_clr  in  1  single-cycle pulse that clears o_frame_err_cnt.
- o_rx_idata  out  DW  I sample, two's complement.
- o_rx_qdata  out  DW  Q sample, two's complement.
- o_rx_iqdata_fp  out  1  high for each cycle in which o_rx_idata and o_rx_qdata hold a new valid sample.
- o_lock  out  1  high when the FSM is in LOCKED.
- o_align_shift  out  1  selected alignment: 0 = NORMAL, 1 = SHIFTED.
- o_frame_err_cnt  out  16  saturating count of bad patterns seen while LOCKED.

## Operation
- Stage 1 registers all four inputs every cycle into r_h, r_l, r_fh and r_fl. It also keeps r_l_d, the previous value of r_l.
- Pattern P = {r_fh, r_fl}:
  - P = 10 is NORMAL. I = r_h, Q = r_l (I on the rising edge, Q on the falling edge, as the transmitter sends).
  - P = 01 is SHIFTED. I = r_l_d, Q = r_h (frame straddles the clock; the falling-edge word is paired with the next rising-edge word).
  - P = 00 or P = 11 is invalid.
- FSM states are SEARCH, CHECK and LOCKED. An 8-bit good counter and an 8-bit bad counter support the FSM.
- SEARCH:
  - On P = 10 or P = 01: latch the candidate mode, set good counter = 1, and go to CHECK. If LOCK_CNT = 1, go directly to LOCKED instead.
  - On an invalid P: stay in SEARCH.
- CHECK:
  - P equals the candidate: increment the good counter. When the counter reaches LOCK_CNT, go to LOCKED and clear the bad counter.
  - P is the other valid pattern: switch the candidate to it, set good counter = 1, and stay in CHECK.
  - P is invalid: go to SEARCH and clear the good counter.
- LOCKED:
  - P equals the locked mode: clear the bad counter, register the sample, and pulse o_rx_iqdata_fp.
  - Any other P, including the opposite valid mode: increment the bad counter and o_frame_err_cnt, hold the data outputs, and drive o_rx_iqdata_fp = 0.
  - When the bad counter reaches UNLOCK_CNT: go to SEARCH, set o_lock = 0, and clear both counters.
- Re-alignment to a different mode happens only after an unlock. There is never a silent mode change while LOCKED.
- The sample that completes lock is not output. The first valid output is the next matching sample.
- o_frame_err_cnt:
  - Saturates at 0xFFFF.
  - i_err_clr takes priority over a same-cycle increment; the counter becomes 0.
  - Counts only while LOCKED.
- SWAP_IQ exchanges the two output buses only. Mode detection is unaffected.

## Timing
- Sample k is the set of inputs present before clock edge k.
- Stage 1 holds sample k after edge k. The FSM and output registers act on it at edge k+1.
- Data latency is 2 clocks, input to o_rx_idata/o_rx_qdata, for NORMAL.
- SHIFTED: I comes from sample k-1 and Q from sample k, and the pair appears after edge k+1.
- Lock timing, with a continuous valid pattern starting at sample 0:
  - o_lock rises after edge LOCK_CNT.
  - The first o_rx_iqdata_fp pulse follows edge LOCK_CNT+1.
  - Pulses then continue every cycle.
- Unlock timing: the UNLOCK_CNT-th consecutive bad sample k drops o_lock after edge k+1.
- Reset:
  - Synchronous: takes effect at the first edge with i_fpga_rst = 1, including mid-lock.
  - All outputs go to 0 and the FSM goes to SEARCH.
  - The counters, stage-1 registers and r_l_d are all cleared.
- There is no back-pressure. The downstream consumer must accept one sample per clock.

## Test plan
- NORMAL lock, LOCK_CNT = 8:
  - Stimulus: frame h/l = 1/0 with data_h = 0x123 and data_l = 0xABC constant.
  - o_lock rises after edge 8, o_rx_iqdata_fp is first high after edge 9, and I = 0x123, Q = 0xABC.
- SHIFTED lock:
  - Stimulus: frame h/l = 0/1 with an incrementing counter on data_l and counter+0x100 on data_h.
  - After lock, o_align_shift = 1 and each output pair is I = n, Q = n+0x100+1.
- Error counting and unlock in NORMAL lock:
  - Stimulus: inject 3 cycles of frame 11, then resume 1/0.
  - o_lock stays 1, o_frame_err_cnt = 3, and the strobe is low for exactly those 3 cycles.
  - Then inject 4 cycles of frame 00. o_lock = 0 after the 4th, and the count is 7.
- Candidate flip in CHECK:
  - Stimulus: 5 cycles of 10, then 01 continuously.
  - No lock occurs until 8 consecutive 01 samples have arrived, and o_align_shift = 1.
- Reset mid-lock plus error-counter behaviour:
  - Assert i_fpga_rst for 1 cycle while locked. All outputs are 0 at the next edge, and relock takes the full LOCK_CNT again.
  - Force 70000 bad cycles: o_frame_err_cnt holds at 0xFFFF.
  - Pulse i_err_clr in the same cycle as an error: the count reads 0.
